gate_tt_checker: RTL and testbench

//   Drives the a/b inputs of a 2-input gate under test and samples its x output.

---
 rtl/gate_tt_checker.sv | 124 ++++++++++++
 tb/tb_gate_tt_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// Truth-table checker for a 2-input gate: walks {a,b} through 00..11, samples x, counts mismatches.
// Optional GATE_CHK_CAPTURE_EN adds fail_vec = {valid, a, b} of the first mismatching vector.
module gate_tt_checker #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] GATE_FUNC     = 4'b1000,
  parameter int         PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
`ifdef GATE_CHK_CAPTURE_EN
  output logic [2:0] fail_vec,
`endif
  output logic [2:0] dbg_state
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // start is accepted only in S_IDLE; busy covers every other state,
  // so there is no ready handshake beyond busy==0.
  state_t          state, state_nxt;
  logic [1:0]      vec;
  logic [PW-1:0]   pass_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            last_vec;
  logic            mismatch;

  assign last_vec  = (vec == 2'd3) && (pass_cnt == PW'(PASSES - 1));
  assign mismatch  = (x != GATE_FUNC[vec]);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt <= SW'(1)) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_vec ? S_DONE : S_DRIVE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a          <= 1'b0;
      b          <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 8'd0;
      vec        <= 2'd0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
`ifdef GATE_CHK_CAPTURE_EN
      fail_vec   <= 3'b000;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          a <= 1'b0;
          b <= 1'b0;
          if (start) begin
            err_cnt  <= 8'd0;
            pass     <= 1'b0;
            vec      <= 2'd0;
            pass_cnt <= '0;
`ifdef GATE_CHK_CAPTURE_EN
            fail_vec <= 3'b000;
`endif
          end
        end
        S_DRIVE: begin
          {a, b}     <= vec;
          settle_cnt <= SW'(SETTLE_CYCLES);
        end
        S_SETTLE: settle_cnt <= settle_cnt - SW'(1);
        S_SAMPLE: begin
          if (mismatch) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef GATE_CHK_CAPTURE_EN
            if (!fail_vec[2]) fail_vec <= {1'b1, vec};
`endif
          end
          vec <= vec + 2'd1;
          if (vec == 2'd3) pass_cnt <= pass_cnt + PW'(1);
          // park the gate inputs low for the whole DONE cycle
          if (last_vec) begin
            a <= 1'b0;
            b <= 1'b0;
          end
        end
        S_DONE: begin
          pass <= (err_cnt == 8'd0);
          a    <= 1'b0;
          b    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench for gate_tt_checker: three parameterisations driven by a modelled gate x=F[{a,b}].
module tb_gate_tt_checker;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   start, a, b, x, busy, done, pass;
  logic [7:0]     err [N];
  logic [2:0]     dbg [N];
`ifdef GATE_CHK_CAPTURE_EN
  logic [2:0]     fv  [N];
`endif
  logic [3:0]     f   [N];
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_fail = 0;
  logic [43:0]    exp_q0[$], exp_q1[$], exp_q2[$];
  bit   [N-1:0]   pchk = '0;
  logic [N-1:0]   ppass = '0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb
    for (int i = 0; i < N; i++) x[i] = f[i][{a[i], b[i]}];

  gate_tt_checker #(.SETTLE_CYCLES(2), .GATE_FUNC(4'b1000), .PASSES(1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .x(x[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err[0]),
`ifdef GATE_CHK_CAPTURE_EN
    .fail_vec(fv[0]),
`endif
    .dbg_state(dbg[0]));

  gate_tt_checker #(.SETTLE_CYCLES(2), .GATE_FUNC(4'b1000), .PASSES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]), .x(x[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err[1]),
`ifdef GATE_CHK_CAPTURE_EN
    .fail_vec(fv[1]),
`endif
    .dbg_state(dbg[1]));

  gate_tt_checker #(.SETTLE_CYCLES(1), .GATE_FUNC(4'b0110), .PASSES(100)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a[2]), .b(b[2]), .x(x[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(err[2]),
`ifdef GATE_CHK_CAPTURE_EN
    .fail_vec(fv[2]),
`endif
    .dbg_state(dbg[2]));

  function automatic logic [3:0] gfunc(input int id);
    return (id == 2) ? 4'b0110 : 4'b1000;
  endfunction
  function automatic int passes(input int id);
    return (id == 0) ? 1 : (id == 1) ? 3 : 100;
  endfunction
  function automatic int settle(input int id);
    return (id == 2) ? 1 : 2;
  endfunction

  // reference model: {done_cycle[31:0], err[7:0], pass, fail_vec[2:0]}
  function automatic logic [43:0] model(input int id, input logic [3:0] fx, input int c0);
    logic [3:0] g = gfunc(id);
    int mism = 0;
    int first = -1;
    int tot;
    int lat;
    logic [7:0] ev;
    logic [2:0] fvv = 3'b000;
    for (int v = 0; v < 4; v++)
      if (fx[v] != g[v]) begin
        mism++;
        if (first < 0) first = v;
      end
    tot = mism * passes(id);
    ev  = (tot > 255) ? 8'd255 : 8'(tot);
    if (first >= 0) fvv = {1'b1, 2'(first)};
    lat = 4 * passes(id) * (settle(id) + 2) + 1;
    return {32'(c0 + lat), ev, (tot == 0), fvv};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [43:0] e);
    case (id)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? exp_q0.size() : (id == 1) ? exp_q1.size() : exp_q2.size();
  endfunction

  task automatic pop_exp(input int id, output logic [43:0] e, output bit ok);
    ok = (qsize(id) != 0);
    e  = '0;
    if (ok)
      case (id)
        0: e = exp_q0.pop_front();
        1: e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
  endtask

  // monitor: pops an expectation on every done pulse, checks pass on the following cycle
  always @(negedge clk) begin
    logic [43:0] e;
    bit ok;
    for (int i = 0; i < N; i++) begin
      if (pchk[i]) begin
        chk($sformatf("pass_%0d", i), pass[i], ppass[i]);
        chk($sformatf("busy_after_done_%0d", i), busy[i], 0);
        pchk[i] = 1'b0;
      end
      if (done[i] === 1'b1) begin
        pop_exp(i, e, ok);
        if (!ok) chk($sformatf("unexpected_done_%0d", i), done[i], 0);
        else begin
          chk($sformatf("done_cycle_%0d", i), cyc, e[43:12]);
          chk($sformatf("err_cnt_%0d", i), err[i], e[11:4]);
          chk($sformatf("ab_in_done_%0d", i), {a[i], b[i]}, 0);
          chk($sformatf("busy_in_done_%0d", i), busy[i], 1);
`ifdef GATE_CHK_CAPTURE_EN
          chk($sformatf("fail_vec_%0d", i), fv[i], e[2:0]);
`endif
          pchk[i]  = 1'b1;
          ppass[i] = e[3];
        end
      end
    end
  end

  // driver tasks
  task automatic wait_idle(input int id);
    int w = 0;
    while ((busy[id] || done[id] || pchk[id]) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) chk("idle_timeout", busy[id], 0);
  endtask

  task automatic run(input int id, input logic [3:0] fx, input bit expect_done, output int c0);
    wait_idle(id);
    f[id] = fx;
    c0 = cyc;
    if (expect_done) push(id, model(id, fx, c0));
    start[id] = 1'b1;
    @(negedge clk);
    start[id] = 1'b0;
  endtask

  task automatic drain(input int id);
    int w = 0;
    while (qsize(id) != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) begin
      $display("stalled instance %0d in state %0d", id, dbg[id]);
      chk($sformatf("drain_timeout_%0d", id), qsize(id), 0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input int id);
    chk($sformatf("rst_ab_%0d", id), {a[id], b[id]}, 0);
    chk($sformatf("rst_busy_done_%0d", id), {busy[id], done[id]}, 0);
    chk($sformatf("rst_pass_%0d", id), pass[id], 0);
    chk($sformatf("rst_err_%0d", id), err[id], 0);
`ifdef GATE_CHK_CAPTURE_EN
    chk($sformatf("rst_fail_vec_%0d", id), fv[id], 0);
`endif
  endtask

  initial begin
    int c0;
    int c1;
    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < N; i++) f[i] = 4'b1000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) check_zero(i);
    rst = 1'b0;
    @(negedge clk);

    // correct AND gate, with the a/b walk observed mid-settle
    run(0, 4'b1000, 1'b1, c0);
    for (int i = 0; i < 4; i++) begin
      while (cyc < c0 + 3 + 4 * i) @(negedge clk);
      chk($sformatf("ab_walk_%0d", i), {a[0], b[0]}, i);
    end
    drain(0);
    run(0, 4'b0000, 1'b1, c0);  // stuck-at-0
    drain(0);
    run(0, 4'b1110, 1'b1, c0);  // OR gate in place of AND
    drain(0);

    // multi-pass and saturation, overlapping on separate instances
    run(1, 4'b1111, 1'b1, c0);
    run(2, 4'b1001, 1'b1, c1);
    drain(1);
    drain(2);

    // reset during settle of vector 2 abandons the run
    run(0, 4'b1000, 1'b0, c0);
    while (cyc < c0 + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero(0);
    repeat (25) @(negedge clk);
    run(0, 4'b1000, 1'b1, c0);
    drain(0);

    // start re-pulsed mid-run is ignored
    run(0, 4'($urandom_range(0, 15)), 1'b1, c0);
    while (cyc < c0 + 5) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    drain(0);
    repeat (20) @(negedge clk);

    // start held through DONE launches a back-to-back run
    wait_idle(0);
    f[0] = 4'b0000;
    c0 = cyc;
    push(0, model(0, 4'b0000, c0));
    start[0] = 1'b1;
    while (cyc < c0 + 18) @(negedge clk);
    f[0] = 4'b1000;
    push(0, model(0, 4'b1000, c0 + 18));
    @(negedge clk);
    chk("err_cleared_on_restart", err[0], 0);
    chk("busy_on_restart", busy[0], 1);
    start[0] = 1'b0;
    drain(0);

    // randomized gate functions
    for (int k = 0; k < 16; k++) begin
      run($urandom_range(0, 1), 4'($urandom_range(0, 15)), 1'b1, c0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    run(2, 4'($urandom_range(0, 15)), 1'b1, c1);
    for (int i = 0; i < N; i++) drain(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
